// File: rtl/truenorth_core.sv
// rtl/truenorth_core.sv - neuromorphic core tile: neuron sweep, axon scheduler, XY spike router
//
// Optional feature macro: TRUENORTH_READBACK_EN (registered neuron-memory read port).
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   tick                 timestep strobe; starts a sweep when idle
//   <dir>_in_*           26-bit packet input per direction {dx[25:17], dy[16:8], axon[7:0]}
//   <dir>_out_*          26-bit packet output per direction, held until out_ready
//   prog_*               neuron record write / read port (410-bit records)
//   core_busy            sweep in progress
//   core_error           OR of error_status
//   error_status         sticky: [0] tick while busy, [1] write while busy
module truenorth_core #(
    parameter int NUM_NEURONS = 256,
    parameter int DELAY_SLOTS = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic [25:0]  north_in_data,
    input  logic         north_in_valid,
    output logic         north_in_ready,
    input  logic [25:0]  south_in_data,
    input  logic         south_in_valid,
    output logic         south_in_ready,
    input  logic [25:0]  east_in_data,
    input  logic         east_in_valid,
    output logic         east_in_ready,
    input  logic [25:0]  west_in_data,
    input  logic         west_in_valid,
    output logic         west_in_ready,
    output logic [25:0]  north_out_data,
    output logic         north_out_valid,
    input  logic         north_out_ready,
    output logic [25:0]  south_out_data,
    output logic         south_out_valid,
    input  logic         south_out_ready,
    output logic [25:0]  east_out_data,
    output logic         east_out_valid,
    input  logic         east_out_ready,
    output logic [25:0]  west_out_data,
    output logic         west_out_valid,
    input  logic         west_out_ready,
    input  logic [409:0] prog_data,
    input  logic [7:0]   prog_addr,
    input  logic         prog_write_en,
    input  logic         prog_read_en,
    output logic [409:0] prog_read_data,
    output logic         prog_ready,
    output logic         core_busy,
    output logic         core_error,
    output logic [7:0]   error_status
);

    // Port index order used throughout: 0 north, 1 south, 2 east, 3 west.
    // Router target code: 0 local, 1 + port index otherwise.

    logic [409:0] mem [NUM_NEURONS];
    logic [255:0] slots [DELAY_SLOTS];
    logic [255:0] vec;
    logic [3:0]   cur;

    logic         busy_q, rd_active, s1_valid;
    logic [7:0]   rd_cnt, addr_q;
    logic [409:0] rec_q;
    logic [1:0]   err_q;

    logic         inj_v;
    logic [25:0]  inj_d;
    logic [3:0]   sk_v, ov_q, in_v, out_rdy;
    logic [25:0]  sk_d [4];
    logic [25:0]  od_q [4];
    logic [25:0]  in_d [4];

    assign in_v    = {west_in_valid, east_in_valid, south_in_valid, north_in_valid};
    assign out_rdy = {west_out_ready, east_out_ready, south_out_ready, north_out_ready};
    assign in_d[0] = north_in_data;
    assign in_d[1] = south_in_data;
    assign in_d[2] = east_in_data;
    assign in_d[3] = west_in_data;

    function automatic logic [8:0] popcount256(input logic [255:0] v);
        logic [8:0] c;
        c = '0;
        for (int i = 0; i < 256; i++) c = c + 9'(v[i]);
        return c;
    endfunction

    // Returns {target[2:0], packet with one hop consumed}; X is resolved before Y.
    function automatic logic [28:0] route(input logic [25:0] p);
        logic signed [8:0] dx, dy;
        dx = p[25:17];
        dy = p[16:8];
        if (dx > 9'sd0)      return {3'd3, dx - 9'sd1, dy, p[7:0]};
        else if (dx < 9'sd0) return {3'd4, dx + 9'sd1, dy, p[7:0]};
        else if (dy > 9'sd0) return {3'd1, dx, dy - 9'sd1, p[7:0]};
        else if (dy < 9'sd0) return {3'd2, dx, dy + 9'sd1, p[7:0]};
        else                 return {3'd0, p};
    endfunction

    // ---------------- sweep update stage ----------------
    logic [7:0]  m_old, params, m_new;
    logic [25:0] dest;
    logic [3:0]  dly;
    logic [8:0]  pc;
    logic [12:0] sum;
    logic        fire, fire_local, stall, wb, sweep_set, inj_load, tick_acc;
    logic [3:0]  sweep_slot;

    always_comb begin
        m_old  = rec_q[153:146];
        params = rec_q[145:138];
        dest   = rec_q[29:4];
        dly    = rec_q[3:0];
        pc     = popcount256(rec_q[409:154] & vec);
        sum    = 13'(m_old) + 13'(params[7:4]) * 13'(pc);
        m_new  = (sum > 13'd255) ? 8'd255 : sum[7:0];
        fire   = {1'b0, m_new} >= (9'(params[3:0]) + 9'd1);
        fire_local = (dest[25:8] == 18'd0);
        // A remote spike cannot be issued while the injection register holds one.
        stall      = s1_valid && fire && !fire_local && inj_v;
        wb         = s1_valid && !stall;
        sweep_set  = wb && fire && fire_local;
        inj_load   = wb && fire && !fire_local;
        sweep_slot = cur + ((dly == 4'd0) ? 4'd1 : dly);
        tick_acc   = tick && !busy_q;
    end

    // ---------------- router arbitration ----------------
    logic [4:0]  src_v, grant;
    logic [28:0] src_rt [5];
    logic [7:0]  free;
    logic        g_found, route_local;
    logic [2:0]  g_dir;
    logic [25:0] g_pkt;
    logic [3:0]  route_slot;

    always_comb begin
        src_v     = {sk_v, inj_v};
        src_rt[0] = route(inj_d);
        for (int i = 0; i < 4; i++) src_rt[i+1] = route(sk_d[i]);
        free = 8'h01;
        for (int i = 0; i < 4; i++) free[i+1] = !ov_q[i] || out_rdy[i];
        grant   = '0;
        g_found = 1'b0;
        g_dir   = 3'd0;
        g_pkt   = '0;
        for (int i = 0; i < 5; i++) begin
            if (!g_found && src_v[i] && free[src_rt[i][28:26]]) begin
                grant[i] = 1'b1;
                g_found  = 1'b1;
                g_dir    = src_rt[i][28:26];
                g_pkt    = src_rt[i][25:0];
            end
        end
        route_local = g_found && (g_dir == 3'd0);
        // Local delivery lands one step after the pointer as updated this cycle.
        route_slot  = (tick_acc ? cur + 4'd1 : cur) + 4'd1;
    end

    // ---------------- scheduler slots ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DELAY_SLOTS; i++) slots[i] <= '0;
            cur <= '0;
            vec <= '0;
        end else begin
            if (tick_acc) begin
                cur              <= cur + 4'd1;
                vec              <= slots[cur + 4'd1];
                slots[cur + 4'd1] <= '0;
            end
            if (sweep_set)   slots[sweep_slot][dest[7:0]]  <= 1'b1;
            if (route_local) slots[route_slot][g_pkt[7:0]] <= 1'b1;
        end
    end

    // ---------------- neuron memory ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (wb)
                mem[addr_q] <= {rec_q[409:154], (fire ? 8'd0 : m_new), rec_q[145:0]};
            else if (prog_write_en && !busy_q)
                mem[prog_addr] <= prog_data;
        end
    end

    // ---------------- sweep control and errors ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= 1'b0;
            rd_active <= 1'b0;
            s1_valid  <= 1'b0;
            rd_cnt    <= '0;
            addr_q    <= '0;
            rec_q     <= '0;
            err_q     <= '0;
        end else begin
            if (tick && busy_q)          err_q[0] <= 1'b1;
            if (prog_write_en && busy_q) err_q[1] <= 1'b1;
            if (tick_acc) begin
                busy_q    <= 1'b1;
                rd_active <= 1'b1;
                rd_cnt    <= '0;
            end else if (!stall) begin
                if (rd_active) begin
                    rec_q     <= mem[rd_cnt];
                    addr_q    <= rd_cnt;
                    s1_valid  <= 1'b1;
                    rd_active <= (rd_cnt != 8'(NUM_NEURONS - 1));
                    rd_cnt    <= rd_cnt + 8'd1;
                end else begin
                    s1_valid <= 1'b0;
                    if (busy_q && !s1_valid) busy_q <= 1'b0;
                end
            end
        end
    end

    // ---------------- packet registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            inj_v <= 1'b0;
            inj_d <= '0;
            sk_v  <= '0;
            ov_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                sk_d[i] <= '0;
                od_q[i] <= '0;
            end
        end else begin
            if (inj_load) begin
                inj_v <= 1'b1;
                inj_d <= dest;
            end else if (grant[0]) begin
                inj_v <= 1'b0;
            end
            for (int i = 0; i < 4; i++) begin
                if (in_v[i] && !sk_v[i]) begin
                    sk_v[i] <= 1'b1;
                    sk_d[i] <= in_d[i];
                end else if (grant[i+1]) begin
                    sk_v[i] <= 1'b0;
                end
                if (g_found && g_dir == 3'(i + 1)) begin
                    ov_q[i] <= 1'b1;
                    od_q[i] <= g_pkt;
                end else if (out_rdy[i]) begin
                    ov_q[i] <= 1'b0;
                end
            end
        end
    end

`ifdef TRUENORTH_READBACK_EN
    always_ff @(posedge clk) begin
        if (rst)               prog_read_data <= '0;
        else if (prog_read_en) prog_read_data <= mem[prog_addr];
    end
`else
    logic unused_read_en;
    assign unused_read_en = prog_read_en;
    assign prog_read_data = '0;
`endif

    assign north_in_ready  = !sk_v[0];
    assign south_in_ready  = !sk_v[1];
    assign east_in_ready   = !sk_v[2];
    assign west_in_ready   = !sk_v[3];
    assign north_out_valid = ov_q[0];
    assign south_out_valid = ov_q[1];
    assign east_out_valid  = ov_q[2];
    assign west_out_valid  = ov_q[3];
    assign north_out_data  = od_q[0];
    assign south_out_data  = od_q[1];
    assign east_out_data   = od_q[2];
    assign west_out_data   = od_q[3];
    assign core_busy       = busy_q;
    assign prog_ready      = !busy_q;
    assign error_status    = {6'd0, err_q};
    assign core_error      = |err_q;

endmodule

// File: tb/tb_truenorth_core.sv
// tb/tb_truenorth_core.sv - directed self-checking bench for truenorth_core
module tb_truenorth_core;

    logic         clk = 1'b0;
    logic         rst, tick;
    logic [25:0]  n_id, s_id, e_id, w_id;
    logic         n_iv, s_iv, e_iv, w_iv;
    logic         n_ir, s_ir, e_ir, w_ir;
    logic [25:0]  n_od, s_od, e_od, w_od;
    logic         n_ov, s_ov, e_ov, w_ov;
    logic         n_or, s_or, e_or, w_or;
    logic [409:0] prog_data, prog_read_data;
    logic [7:0]   prog_addr, error_status;
    logic         prog_write_en, prog_read_en, prog_ready, core_busy, core_error;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    truenorth_core dut (
        .clk(clk), .rst(rst), .tick(tick),
        .north_in_data(n_id), .north_in_valid(n_iv), .north_in_ready(n_ir),
        .south_in_data(s_id), .south_in_valid(s_iv), .south_in_ready(s_ir),
        .east_in_data(e_id),  .east_in_valid(e_iv),  .east_in_ready(e_ir),
        .west_in_data(w_id),  .west_in_valid(w_iv),  .west_in_ready(w_ir),
        .north_out_data(n_od), .north_out_valid(n_ov), .north_out_ready(n_or),
        .south_out_data(s_od), .south_out_valid(s_ov), .south_out_ready(s_or),
        .east_out_data(e_od),  .east_out_valid(e_ov),  .east_out_ready(e_or),
        .west_out_data(w_od),  .west_out_valid(w_ov),  .west_out_ready(w_or),
        .prog_data(prog_data), .prog_addr(prog_addr), .prog_write_en(prog_write_en),
        .prog_read_en(prog_read_en), .prog_read_data(prog_read_data),
        .prog_ready(prog_ready), .core_busy(core_busy), .core_error(core_error),
        .error_status(error_status)
    );

    task automatic check(input string tag, input logic [409:0] obs, input logic [409:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [409:0] mk_rec(input int syn_bit, input logic [7:0] params,
                                            input logic [25:0] dest, input logic [3:0] dly);
        logic [409:0] r;
        r = '0;
        r[154 + syn_bit] = 1'b1;
        r[145:138] = params;
        r[29:4]    = dest;
        r[3:0]     = dly;
        return r;
    endfunction

    function automatic logic [25:0] pkt(input logic [8:0] dx, input logic [8:0] dy, input logic [7:0] ax);
        return {dx, dy, ax};
    endfunction

    task automatic set_in(input int port, input logic v, input logic [25:0] d);
        case (port)
            0: begin n_iv = v; n_id = d; end
            1: begin s_iv = v; s_id = d; end
            2: begin e_iv = v; e_id = d; end
            default: begin w_iv = v; w_id = d; end
        endcase
    endtask

    task automatic inject(input int port, input logic [25:0] d);
        @(negedge clk);
        set_in(port, 1'b1, d);
        @(posedge clk);
        #1 set_in(port, 1'b0, 26'd0);
    endtask

    task automatic do_tick();
        @(negedge clk);
        tick = 1'b1;
        @(posedge clk);
        #1 tick = 1'b0;
    endtask

    task automatic prog_write(input logic [7:0] a, input logic [409:0] d);
        @(negedge clk);
        prog_addr = a; prog_data = d; prog_write_en = 1'b1;
        @(posedge clk);
        #1 prog_write_en = 1'b0;
    endtask

    task automatic prog_read(input logic [7:0] a);
        @(negedge clk);
        prog_addr = a; prog_read_en = 1'b1;
        @(posedge clk);
        #1 prog_read_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic port_case(input string tag, input int in_port, input logic [25:0] p,
                             input int out_port, input logic [25:0] exp);
        logic        v;
        logic [25:0] d;
        inject(in_port, p);
        @(posedge clk);
        @(negedge clk);
        case (out_port)
            0: begin v = n_ov; d = n_od; end
            1: begin v = s_ov; d = s_od; end
            2: begin v = e_ov; d = e_od; end
            default: begin v = w_ov; d = w_od; end
        endcase
        check({tag, "_valid"}, 410'(v), 410'(1));
        check({tag, "_data"}, 410'(d), 410'(exp));
    endtask

    logic [409:0] rec_a, rec_b, exp_rd;
    int busy_cycles, east_hits, other_hits;
    logic [25:0] east_seen;

    initial begin
        rst = 1'b1; tick = 1'b0;
        n_iv = 0; s_iv = 0; e_iv = 0; w_iv = 0;
        n_id = 0; s_id = 0; e_id = 0; w_id = 0;
        n_or = 1; s_or = 1; e_or = 1; w_or = 1;
        prog_data = '0; prog_addr = '0; prog_write_en = 0; prog_read_en = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        // reset state
        check("rst_out_valid", 410'({n_ov, s_ov, e_ov, w_ov}), 410'(0));
        check("rst_out_data", 410'({n_od, s_od, e_od, w_od}), 410'(0));
        check("rst_in_ready", 410'({n_ir, s_ir, e_ir, w_ir}), 410'(4'hF));
        check("rst_prog_ready", 410'(prog_ready), 410'(1));
        check("rst_busy", 410'(core_busy), 410'(0));
        check("rst_core_error", 410'(core_error), 410'(0));
        check("rst_error_status", 410'(error_status), 410'(0));
        check("rst_read_data", prog_read_data, 410'(0));

        // clear every neuron, then load the two-neuron chain
        for (int i = 0; i < 256; i++) prog_write(8'(i), '0);
        prog_write(8'd0,  mk_rec(10, 8'h20, pkt(9'd0, 9'd0, 8'd20), 4'd2));
        prog_write(8'd10, mk_rec(20, 8'h20, pkt(9'd1, 9'd0, 8'd30), 4'd2));

        inject(3, pkt(9'd0, 9'd0, 8'd10));
        repeat (3) @(posedge clk);
        #1;

        for (int t = 1; t <= 3; t++) begin
            do_tick();
            busy_cycles = 0; east_hits = 0; other_hits = 0; east_seen = '0;
            for (int c = 0; c < 299; c++) begin
                @(negedge clk);
                if (core_busy) busy_cycles++;
                if (e_ov) begin east_hits++; east_seen = e_od; end
                if (n_ov || s_ov || w_ov) other_hits++;
            end
            check($sformatf("tick%0d_busy_len", t), 410'(busy_cycles), 410'(258));
            check($sformatf("tick%0d_east_hits", t), 410'(east_hits), 410'((t == 3) ? 1 : 0));
            check($sformatf("tick%0d_other_hits", t), 410'(other_hits), 410'(0));
            if (t == 3) check("tick3_east_data", 410'(east_seen), 410'(26'h00001E));
        end
        check("chain_no_error", 410'(error_status), 410'(0));

        // single-hop routing through each port
        port_case("north", 0, pkt(9'd0, 9'd1, 8'd5), 0, 26'd5);
        port_case("south", 1, pkt(9'd0, 9'h1FF, 8'd6), 1, 26'd6);
        port_case("east",  2, pkt(9'd1, 9'd0, 8'd7), 2, 26'd7);
        port_case("west",  3, pkt(9'h1FF, 9'd0, 8'd8), 3, 26'd8);

        // backpressure on the east output
        @(negedge clk);
        e_or = 1'b0;
        inject(2, pkt(9'd1, 9'd0, 8'h11));
        @(posedge clk);
        inject(2, pkt(9'd1, 9'd0, 8'h12));
        @(posedge clk);
        @(negedge clk);
        check("bp_hold_valid", 410'(e_ov), 410'(1));
        check("bp_hold_data", 410'(e_od), 410'(26'h11));
        check("bp_skid_full", 410'(e_ir), 410'(0));
        e_or = 1'b1;
        @(negedge clk);
        check("bp_second_valid", 410'(e_ov), 410'(1));
        check("bp_second_data", 410'(e_od), 410'(26'h12));
        check("bp_skid_free", 410'(e_ir), 410'(1));
        @(negedge clk);
        check("bp_drained", 410'(e_ov), 410'(0));

        // readback, then errors while busy
        rec_a = '0; rec_b = '0;
        for (int i = 0; i < 13; i++) begin
            rec_a = (rec_a << 32) | 410'($urandom());
            rec_b = (rec_b << 32) | 410'($urandom());
        end
        rec_a[153:146] = 8'd0;
`ifdef TRUENORTH_READBACK_EN
        exp_rd = rec_a;
`else
        exp_rd = '0;
`endif
        prog_write(8'h55, rec_a);
        prog_read(8'h55);
        check("readback_idle", prog_read_data, exp_rd);

        do_tick();
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("busy_prog_ready", 410'(prog_ready), 410'(0));
        do_tick();
        @(negedge clk);
        check("err_tick_status", 410'(error_status), 410'(8'h01));
        check("err_tick_core_error", 410'(core_error), 410'(1));
        prog_write(8'h55, rec_b);
        @(negedge clk);
        check("err_write_status", 410'(error_status), 410'(8'h03));
        prog_read(8'h55);
        check("readback_busy", prog_read_data, exp_rd);

        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!core_busy) break;
        end
        check("sweep_done", 410'(core_busy), 410'(0));
        check("ready_after_sweep", 410'(prog_ready), 410'(1));
        prog_read(8'h55);
        check("readback_after", prog_read_data, exp_rd);
        check("err_sticky", 410'(error_status), 410'(8'h03));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
